// File: rtl/cam_pattern_tx_if.sv
// Camera-side byte bus: sync strobes, pixel byte and frame bookkeeping.
// The master drives every signal; the slave (capture path or bench) only observes.
interface cam_pattern_tx_if;
    logic       href;
    logic       vsync;
    logic [7:0] cam_data;
    logic       frame_start;
    logic [7:0] frame_count;

    // No back-pressure: a byte is valid on every cycle href is high.
    modport master (output href, vsync, cam_data, frame_start, frame_count);
    modport slave  (input  href, vsync, cam_data, frame_start, frame_count);
endinterface

// File: rtl/cam_pattern_tx.sv
// OV7670-style frame generator with test patterns.
// Outputs are registered from the next-state values, so they stay aligned with the counters.
module cam_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    cam_pattern_tx_if.master bus,
    output logic [2:0]       dbg_state
);
    localparam int L            = 2 * H_ACTIVE + H_BLANK;
    localparam int F            = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int BW           = (L > 1) ? $clog2(L) : 1;
    localparam int LW           = (F > 1) ? $clog2(F) : 1;
    localparam int FIRST_ACTIVE = VSYNC_LINES + V_BACK;
    localparam int BAR_W        = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        s_off    = 3'd0,
        s_vsync  = 3'd1,
        s_vback  = 3'd2,
        s_active = 3'd3,
        s_vfront = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   byte_cnt, byte_n;
    logic [LW-1:0]   line_cnt, line_n;
    logic [1:0]      pat_q, pat_n;
    logic [7:0]      fc_q, fc_n;
    logic            href_q, vsync_q, fs_q;
    logic [7:0]      data_q;

    logic            href_n, vsync_n, fs_n;
    logic [7:0]      data_n;
    logic [9:0]      x, y;
    logic [2:0]      bar;
    logic [15:0]     pixel;

    // Region of the frame a given line belongs to; empty regions fall through naturally.
    function automatic state_t line_state(input logic [LW-1:0] ln);
        int lv;
        lv = int'(ln);
        if (lv < VSYNC_LINES)                     return s_vsync;
        else if (lv < FIRST_ACTIVE)               return s_vback;
        else if (lv < FIRST_ACTIVE + V_ACTIVE)    return s_active;
        else                                      return s_vfront;
    endfunction

    always_comb begin
        state_n = state;
        byte_n  = byte_cnt;
        line_n  = line_cnt;
        pat_n   = pat_q;
        fc_n    = fc_q;
        fs_n    = 1'b0;
        href_n  = 1'b0;
        vsync_n = 1'b0;
        data_n  = 8'h00;
        x       = '0;
        y       = '0;
        bar     = '0;
        pixel   = '0;

        case (state)
            s_off: begin
                if (enable) begin
                    state_n = s_vsync;
                    byte_n  = '0;
                    line_n  = '0;
                    pat_n   = pattern_sel;
                    fs_n    = 1'b1;
                end
            end
            default: begin
                if (int'(byte_cnt) == L - 1) begin
                    byte_n = '0;
                    if (int'(line_cnt) == F - 1) begin
                        // Frame boundary: count it, then either restart or go idle.
                        line_n = '0;
                        fc_n   = fc_q + 8'd1;
                        if (enable) begin
                            state_n = s_vsync;
                            pat_n   = pattern_sel;
                            fs_n    = 1'b1;
                        end else begin
                            state_n = s_off;
                        end
                    end else begin
                        line_n  = line_cnt + LW'(1);
                        state_n = line_state(line_n);
                    end
                end else begin
                    byte_n = byte_cnt + BW'(1);
                end
            end
        endcase

        href_n  = (state_n == s_active) && (int'(byte_n) < 2 * H_ACTIVE);
        vsync_n = (state_n == s_vsync);

        x   = 10'(byte_n >> 1);
        y   = 10'(line_n) - 10'(FIRST_ACTIVE);
        bar = 3'(x / 10'(BAR_W));

        case (pat_n)
            2'd0: pixel = {6'b0, x};
            2'd1: pixel = {6'b0, y};
            2'd2: begin
                case (bar)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            default: pixel = {fc_n, x[7:0]};
        endcase

        if (href_n) data_n = byte_n[0] ? pixel[7:0] : pixel[15:8];
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state    <= s_off;
            byte_cnt <= '0;
            line_cnt <= '0;
            pat_q    <= '0;
            fc_q     <= '0;
            href_q   <= 1'b0;
            vsync_q  <= 1'b0;
            fs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_n;
            line_cnt <= line_n;
            pat_q    <= pat_n;
            fc_q     <= fc_n;
            href_q   <= href_n;
            vsync_q  <= vsync_n;
            fs_q     <= fs_n;
            data_q   <= data_n;
        end
    end

    assign bus.href        = href_q;
    assign bus.vsync       = vsync_q;
    assign bus.cam_data    = data_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_count = fc_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx with small timing: L=22 cycles per line, F=6 lines, 132 cycles per frame.
// Expected bytes are queued per frame; a negedge monitor pops one per href cycle.
module tb_cam_pattern_tx;
    localparam int H_ACTIVE    = 8;
    localparam int H_BLANK     = 6;
    localparam int V_ACTIVE    = 3;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int L           = 22;
    localparam int FRAME_CYC   = 132;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [2:0] dbg_state;

    cam_pattern_tx_if bus();

    cam_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
    ) dut (
        .pclk(pclk),
        .reset(reset),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 pclk = ~pclk;
    int cyc = 0;
    always @(posedge pclk) cyc++;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input int pat, input int x, input int y,
                                              input logic [7:0] fc);
        logic [15:0] bars [8];
        logic [9:0]  xv;
        logic [9:0]  yv;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        xv = 10'(x);
        yv = 10'(y);
        case (pat)
            0:       return {6'b0, xv};
            1:       return {6'b0, yv};
            2:       return bars[x / (H_ACTIVE / 8)];
            default: return {fc, xv[7:0]};
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [7:0] fc);
        logic [15:0] px;
        for (int ln = 0; ln < V_ACTIVE; ln++) begin
            for (int b = 0; b < 2 * H_ACTIVE; b++) begin
                px = exp_pixel(pat, b / 2, ln, fc);
                exp_q.push_back((b % 2 == 1) ? px[7:0] : px[15:8]);
            end
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_fs(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.frame_start) break;
        end
        check("wait_frame_start", 32'(bus.frame_start), 32'd1);
    endtask

    task automatic wait_href(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.href) break;
        end
        check("wait_href", 32'(bus.href), 32'd1);
    endtask

    task automatic wait_fc(input logic [7:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.frame_count == target) break;
        end
        check("wait_frame_count", 32'(bus.frame_count), 32'(target));
    endtask

    task automatic idle_check(input logic [7:0] fc);
        repeat (30) step();
        check("idle_href", 32'(bus.href), 32'd0);
        check("idle_vsync", 32'(bus.vsync), 32'd0);
        check("idle_cam_data", 32'(bus.cam_data), 32'd0);
        check("idle_frame_start", 32'(bus.frame_start), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);
        check("idle_frame_count", 32'(bus.frame_count), 32'(fc));
    endtask

    // Monitor / scoreboard
    logic       href_p = 1'b0;
    logic       vsync_p = 1'b0;
    logic [7:0] fc_p = 8'd0;
    int         href_len = 0;
    int         vs_len = 0;
    int         last_fs = 0;
    bit         fs_valid = 1'b0;
    int         fs_total = 0;
    bit         fc_chg;

    always @(negedge pclk) begin
        if (!reset) begin
            href_p   = 1'b0;
            vsync_p  = 1'b0;
            fc_p     = 8'd0;
            href_len = 0;
            vs_len   = 0;
            fs_valid = 1'b0;
        end else begin
            fc_chg = (bus.frame_count != fc_p);
            if (fc_chg) begin
                check("frame_count_step", 32'(bus.frame_count), 32'(fc_p + 8'd1));
                if (fs_valid) check("frame_length", 32'(cyc - last_fs), 32'(FRAME_CYC));
            end
            if (bus.frame_start) begin
                fs_total++;
                check("frame_start_on_vsync_rise", 32'({vsync_p, bus.vsync}), 32'b01);
                if (fs_valid && fc_chg) check("frame_spacing", 32'(cyc - last_fs), 32'(FRAME_CYC));
                last_fs  = cyc;
                fs_valid = 1'b1;
            end
            if (bus.href) begin
                href_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none at cycle %0d",
                             bus.cam_data, cyc);
                end else begin
                    check("cam_data", 32'(bus.cam_data), 32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_data_zero", 32'(bus.cam_data), 32'd0);
                if (href_p) check("href_length", 32'(href_len), 32'(2 * H_ACTIVE));
                href_len = 0;
            end
            if (bus.vsync) begin
                vs_len++;
            end else begin
                if (vsync_p) check("vsync_length", 32'(vs_len), 32'(VSYNC_LINES * L));
                vs_len = 0;
            end
            href_p  = bus.href;
            vsync_p = bus.vsync;
            fc_p    = bus.frame_count;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        #1 reset = 1'b0;
        #2;
        check("reset_href", 32'(bus.href), 32'd0);
        check("reset_vsync", 32'(bus.vsync), 32'd0);
        check("reset_cam_data", 32'(bus.cam_data), 32'd0);
        check("reset_frame_start", 32'(bus.frame_start), 32'd0);
        check("reset_frame_count", 32'(bus.frame_count), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        repeat (2) step();

        // Pattern 0 frame, switch to 3 mid-frame (takes effect next frame), then drop enable
        reset = 1'b1;
        pattern_sel = 2'd0;
        push_frame(0, 8'd0);
        push_frame(3, 8'd1);
        enable = 1'b1;
        wait_fs(10);
        repeat (50) step();
        pattern_sel = 2'd3;
        wait_fs(200);
        repeat (40) step();
        enable = 1'b0;
        wait_fc(8'd2, 300);
        idle_check(8'd2);

        // Colour bars, enable dropped early
        pattern_sel = 2'd2;
        push_frame(2, 8'd2);
        enable = 1'b1;
        wait_fs(10);
        enable = 1'b0;
        wait_fc(8'd3, 300);
        idle_check(8'd3);

        // Row ramp, two back-to-back frames
        pattern_sel = 2'd1;
        push_frame(1, 8'd3);
        push_frame(1, 8'd4);
        enable = 1'b1;
        wait_fs(10);
        wait_fs(200);
        enable = 1'b0;
        wait_fc(8'd5, 300);
        idle_check(8'd5);

        // Asynchronous reset in the middle of an active line
        pattern_sel = 2'd0;
        push_frame(0, 8'd5);
        enable = 1'b1;
        wait_fs(10);
        wait_href(100);
        repeat (5) @(posedge pclk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_href", 32'(bus.href), 32'd0);
        check("async_reset_vsync", 32'(bus.vsync), 32'd0);
        check("async_reset_cam_data", 32'(bus.cam_data), 32'd0);
        check("async_reset_frame_count", 32'(bus.frame_count), 32'd0);
        check("async_reset_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        push_frame(0, 8'd0);
        repeat (3) step();
        reset = 1'b1;
        wait_fs(10);
        enable = 1'b0;
        wait_fc(8'd1, 300);
        idle_check(8'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_start_total", 32'(fs_total), 32'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_pattern_tx.md
Name: cam_pattern_tx

Overview:
Synthesizable camera-side byte-stream transmitter that emits OV7670-style frames (vsync, href, 8-bit data, two bytes per RGB565 pixel) with programmable timing and built-in test patterns. It drives the capture path on-board, removing the need for a physical sensor during bring-up, and serves as the stimulus source in capture-path simulations. All outputs are registered in the pclk domain.

Parameters:
H_ACTIVE, 640, active pixels per line (bytes per active line = 2*H_ACTIVE)
H_BLANK, 144, href-low pclk cycles after active bytes on every line
V_ACTIVE, 480, active lines per frame
VSYNC_LINES, 3, lines with vsync high at frame start
V_BACK, 17, blank lines between vsync fall and first active line
V_FRONT, 10, blank lines after last active line

Ports:
pclk  input  1  pixel clock; all state updates on rising edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
enable  input  1  request frames; sampled only at frame boundaries
pattern_sel  input  2  test pattern, latched at frame start
href  output  1  high during active bytes of active lines
vsync  output  1  high during first VSYNC_LINES lines of a frame
cam_data  output  8  pixel byte; high byte first, 0x00 when href low
frame_start  output  1  one-cycle pulse coincident with vsync rising
frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (reset=0, async): state s_off; href=0, vsync=0, cam_data=0x00, frame_start=0, frame_count=0, byte/line counters 0. Takes effect immediately, including mid-line.
- Line length L = 2*H_ACTIVE + H_BLANK cycles, identical for every line (blank lines included). Frame = F = VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT lines.
- Counters: byte_cnt 0..L-1, line_cnt 0..F-1; widths via $clog2. byte_cnt wraps to 0 and line_cnt increments on the same edge.
- States: s_off, s_vsync, s_vback, s_active, s_vfront.
  s_off: outputs idle; if enable=1 at an edge -> s_vsync, byte_cnt=line_cnt=0; on that same edge vsync<=1, frame_start<=1.
  s_vsync: vsync=1 for VSYNC_LINES*L cycles -> s_vback.
  s_vback: V_BACK*L cycles -> s_active (skipped if V_BACK=0).
  s_active: per line, href=1 for byte_cnt 0..2*H_ACTIVE-1, then 0 for H_BLANK cycles; V_ACTIVE lines -> s_vfront.
  s_vfront: V_FRONT*L cycles; on last cycle frame_count+=1; then enable=1 -> s_vsync (new frame, back-to-back, frame_start pulses) else s_off.
- enable deasserted mid-frame: current frame completes fully and is counted; enable changes mid-frame are ignored otherwise.
- pattern_sel latched on the edge entering s_vsync; constant for the whole frame.
- Pixel coordinates: x = byte_cnt>>1 (10 bits), y = line_cnt - (VSYNC_LINES+V_BACK) (10 bits). Even byte_cnt -> pixel[15:8], odd -> pixel[7:0].
- Patterns (16-bit pixel):
  0 column ramp: {6'b0, x}
  1 row ramp: {6'b0, y}
  2 colour bars, bar = x / (H_ACTIVE/8): FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000
  3 frame tag: {frame_count, x[7:0]}
- Output timing: href, vsync, cam_data change together on the same edge; a byte is valid on every cycle href=1; no partial pixels (href always spans an even byte count).
- H_ACTIVE must be a multiple of 8; zero-valued V_BACK/V_FRONT are legal; VSYNC_LINES>=1, V_ACTIVE>=1.

Test Plan:
(Small params: H_ACTIVE=8, H_BLANK=6, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 -> L=22, F=6, frame = 132 cycles.)
- Reset release, enable=1, pattern 0 -> vsync high 22 cycles, frame_start 1 cycle; 3 href pulses of 16 cycles, 6 low between; line 0 bytes 00 00 00 01 ... 00 07; frame_count 0->1 at cycle 132.
- Pattern 2 -> first active line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; cam_data=00 while href=0.
- Pattern 1, two back-to-back frames -> active lines carry 0x0000/0x0001/0x0002 per line; second vsync rises exactly 132 cycles after first; frame_count=2.
- enable dropped at cycle 40 -> frame completes (cycle 132), frame_count=1, then s_off: all outputs 0, no further frame_start.
- reset=0 mid active line -> href, vsync, cam_data go 0 without a clock edge; frame_count=0; after release with enable=1, next frame starts from line 0.
- pattern_sel changed mid-frame 0->3 -> current frame stays pattern 0; next frame bytes {frame_count, x}: 01 00 01 01 ... .
